// File: rtl/pipe_stage_skid.sv
// Fetch-to-decode pipeline stage with valid/ready handshake and an optional 2-entry skid buffer.
// All state updates on the falling clock edge. A saturating counter tracks backpressure cycles.
module pipe_stage_skid #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 32,
    parameter logic [NB_DATA-1:0] NOP_INSTR = '0,
    parameter int                 SKID_EN   = 1,
    parameter int                 NB_CNT    = 16
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               enable_pipe_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [NB_ADDR-1:0] pc_i,
    input  logic [NB_DATA-1:0] instruction_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [NB_ADDR-1:0] pc_o,
    output logic [NB_DATA-1:0] instruction_o,
    output logic [NB_CNT-1:0]  stall_count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (&v) ? v : v + NB_CNT'(1);
    endfunction

    state_t             state_p0, state_nxt;
    logic [NB_ADDR-1:0] main_pc_p0, main_pc_nxt;
    logic [NB_DATA-1:0] main_instr_p0, main_instr_nxt;
    logic [NB_ADDR-1:0] skid_pc_p0, skid_pc_nxt;
    logic [NB_DATA-1:0] skid_instr_p0, skid_instr_nxt;
    logic [NB_CNT-1:0]  stall_cnt_p0, stall_cnt_nxt;
    logic               vld_p0;
    logic               in_xfer;
    logic               out_xfer;

    assign vld_p0        = (state_p0 != ST_EMPTY);
    assign valid_o       = vld_p0;
    assign pc_o          = main_pc_p0;
    assign instruction_o = main_instr_p0;
    assign stall_count_o = stall_cnt_p0;

    // Without the skid entry, acceptance must look through to the downstream ready.
    always_comb begin
        if (SKID_EN != 0) begin
            ready_o = enable_pipe_i & ~flush_i & (state_p0 != ST_SKID);
        end else begin
            ready_o = enable_pipe_i & ~flush_i & (~vld_p0 | ready_i);
        end
    end

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = vld_p0 & ready_i & enable_pipe_i;

    always_comb begin
        state_nxt      = state_p0;
        main_pc_nxt    = main_pc_p0;
        main_instr_nxt = main_instr_p0;
        skid_pc_nxt    = skid_pc_p0;
        skid_instr_nxt = skid_instr_p0;
        stall_cnt_nxt  = stall_cnt_p0;

        if (vld_p0 && !ready_i && enable_pipe_i) begin
            stall_cnt_nxt = sat_inc(stall_cnt_p0);
        end

        if (flush_i) begin
            state_nxt      = ST_EMPTY;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP_INSTR;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
        end else if (enable_pipe_i) begin
            case (state_p0)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_pc_nxt    = pc_i;
                        main_instr_nxt = instruction_i;
                        state_nxt      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_nxt    = pc_i;
                        main_instr_nxt = instruction_i;
                    end else if (in_xfer && (SKID_EN != 0)) begin
                        skid_pc_nxt    = pc_i;
                        skid_instr_nxt = instruction_i;
                        state_nxt      = ST_SKID;
                    end else if (out_xfer) begin
                        main_pc_nxt    = '0;
                        main_instr_nxt = NOP_INSTR;
                        state_nxt      = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_pc_nxt    = skid_pc_p0;
                        main_instr_nxt = skid_instr_p0;
                        skid_pc_nxt    = '0;
                        skid_instr_nxt = NOP_INSTR;
                        state_nxt      = ST_FULL;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Stage boundary: main/skid entries and counter, falling edge
    always_ff @(negedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_p0      <= ST_EMPTY;
            main_pc_p0    <= '0;
            main_instr_p0 <= NOP_INSTR;
            skid_pc_p0    <= '0;
            skid_instr_p0 <= NOP_INSTR;
            stall_cnt_p0  <= '0;
        end else begin
            state_p0      <= state_nxt;
            main_pc_p0    <= main_pc_nxt;
            main_instr_p0 <= main_instr_nxt;
            skid_pc_p0    <= skid_pc_nxt;
            skid_instr_p0 <= skid_instr_nxt;
            stall_cnt_p0  <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid, flush, enable hold, saturation, async reset.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        enable_pipe;
    logic        flush;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;

    logic        ready_a, valid_a;
    logic [31:0] pc_a, instr_a;
    logic [15:0] cnt_a;
    logic        ready_b, valid_b;
    logic [31:0] pc_b, instr_b;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .NB_DATA(32), .NB_ADDR(32), .NOP_INSTR(NOP), .SKID_EN(1), .NB_CNT(16)
    ) dut_a (
        .clock_i(clk), .reset_n_i(reset_n), .enable_pipe_i(enable_pipe), .flush_i(flush),
        .valid_i(valid_in), .ready_o(ready_a), .pc_i(pc_in), .instruction_i(instr_in),
        .valid_o(valid_a), .ready_i(ready_in), .pc_o(pc_a), .instruction_o(instr_a),
        .stall_count_o(cnt_a)
    );

    pipe_stage_skid #(
        .NB_DATA(32), .NB_ADDR(32), .NOP_INSTR(NOP), .SKID_EN(1), .NB_CNT(4)
    ) dut_b (
        .clock_i(clk), .reset_n_i(reset_n), .enable_pipe_i(enable_pipe), .flush_i(flush),
        .valid_i(valid_in), .ready_o(ready_b), .pc_i(pc_in), .instruction_i(instr_in),
        .valid_o(valid_b), .ready_i(ready_in), .pc_o(pc_b), .instruction_o(instr_b),
        .stall_count_o(cnt_b)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        valid_in = v;
        pc_in    = pc;
        instr_in = instr_of(pc);
    endtask

    initial begin
        reset_n = 1'b1; enable_pipe = 1'b1; flush = 1'b0;
        valid_in = 1'b0; ready_in = 1'b0; pc_in = '0; instr_in = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_valid", valid_a, 0);
        check("rst_pc", pc_a, 0);
        check("rst_instr", instr_a, NOP);
        check("rst_cnt", cnt_a, 0);
        check("rst_ready", ready_a, 1);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Streaming 0x0, 0x4, 0x8 with no bubbles
        ready_in = 1'b1;
        offer(1'b1, 32'h0);
        #1 check("strm_ready", ready_a, 1);
        edge_step();
        check("strm0_valid", valid_a, 1);
        check("strm0_pc", pc_a, 32'h0);
        check("strm0_instr", instr_a, instr_of(32'h0));
        offer(1'b1, 32'h4);
        edge_step();
        check("strm1_valid", valid_a, 1);
        check("strm1_pc", pc_a, 32'h4);
        offer(1'b1, 32'h8);
        edge_step();
        check("strm2_pc", pc_a, 32'h8);
        check("strm2_instr", instr_a, instr_of(32'h8));
        offer(1'b0, 32'h0);
        edge_step();
        check("strm_drain_valid", valid_a, 0);
        check("strm_drain_pc", pc_a, 0);
        check("strm_drain_instr", instr_a, NOP);
        check("strm_cnt", cnt_a, 0);

        // Skid: FULL with 0x10, offer 0x14 under backpressure
        ready_in = 1'b0;
        offer(1'b1, 32'h10);
        edge_step();
        check("skid_full_pc", pc_a, 32'h10);
        check("skid_full_ready", ready_a, 1);
        offer(1'b1, 32'h14);
        edge_step();
        check("skid_ready_low", ready_a, 0);
        check("skid_pc_hold", pc_a, 32'h10);
        check("skid_cnt1", cnt_a, 1);
        offer(1'b1, 32'h18);
        edge_step();
        check("skid_hold_pc", pc_a, 32'h10);
        check("skid_cnt2", cnt_a, 2);
        offer(1'b0, 32'h0);
        ready_in = 1'b1;
        edge_step();
        check("skid_drain1_pc", pc_a, 32'h14);
        check("skid_drain1_instr", instr_a, instr_of(32'h14));
        check("skid_drain1_valid", valid_a, 1);
        edge_step();
        check("skid_drain2_valid", valid_a, 0);
        check("skid_cnt_after", cnt_a, 2);

        // Flush in SKID with a valid offer
        ready_in = 1'b0;
        offer(1'b1, 32'h20);
        edge_step();
        offer(1'b1, 32'h24);
        edge_step();
        check("flush_pre_cnt", cnt_a, 3);
        flush = 1'b1;
        offer(1'b1, 32'h28);
        #1 check("flush_ready", ready_a, 0);
        edge_step();
        check("flush_valid", valid_a, 0);
        check("flush_pc", pc_a, 0);
        check("flush_instr", instr_a, NOP);
        check("flush_cnt_kept", cnt_a, 4);
        flush = 1'b0;
        offer(1'b0, 32'h0);
        ready_in = 1'b1;
        edge_step();
        check("flush_drop_valid", valid_a, 0);

        // Enable low holds everything
        ready_in = 1'b0;
        offer(1'b1, 32'h30);
        edge_step();
        offer(1'b0, 32'h0);
        enable_pipe = 1'b0;
        #1 check("en_low_ready", ready_a, 0);
        repeat (3) edge_step();
        check("en_low_valid", valid_a, 1);
        check("en_low_pc", pc_a, 32'h30);
        check("en_low_cnt", cnt_a, 4);
        enable_pipe = 1'b1;
        edge_step();
        check("en_high_cnt1", cnt_a, 5);
        edge_step();
        check("en_high_cnt2", cnt_a, 6);
        enable_pipe = 1'b0;
        ready_in = 1'b1;
        edge_step();
        check("en_low_no_out", pc_a, 32'h30);
        enable_pipe = 1'b1;
        edge_step();
        check("en_out_valid", valid_a, 0);

        // Saturation on the 4-bit instance
        check("sat_b_pre", cnt_b, 6);
        ready_in = 1'b0;
        offer(1'b1, 32'h40);
        edge_step();
        offer(1'b0, 32'h0);
        repeat (20) edge_step();
        check("sat_b_cnt", cnt_b, 15);
        check("sat_a_cnt", cnt_a, 26);
        check("sat_b_pc", pc_b, 32'h40);

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", valid_a, 0);
        check("arst_pc", pc_a, 0);
        check("arst_instr", instr_a, NOP);
        check("arst_cnt_a", cnt_a, 0);
        check("arst_cnt_b", cnt_b, 0);
        #2 reset_n = 1'b1;
        ready_in = 1'b1;
        offer(1'b1, 32'h50);
        edge_step();
        check("post_rst_valid", valid_a, 1);
        check("post_rst_pc", pc_a, 32'h50);
        check("post_rst_instr", instr_a, instr_of(32'h50));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
